// File: rtl/codec_cfg_pkg.sv
// Shared state encoding and transfer-direction constants for the codec config sequencer.
// Readback states exist only when CFG_READBACK_EN is defined.
package codec_cfg_pkg;

`ifdef CFG_READBACK_EN
  typedef enum logic [2:0] {
    ST_PWRUP    = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_RB_ISSUE = 3'd5,
    ST_RB_WAIT  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
`endif

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Loadable down-counter with zero/last flags; last marks the final counted cycle.
// Holds at zero; load wins over decrement.
module cfg_delay_cnt #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec register table and issues one valid/ready write per entry, with power-up hold and
// inter-write gap; outputs hold while ready is low. CFG_READBACK_EN adds a read-back compare per entry.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int PWRUP_CYCLES = 1024,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  output logic [$clog2(NUM_REGS > 1 ? NUM_REGS : 2)-1:0] tbl_idx,
  input  logic [ADDR_W-1:0]                           tbl_addr,
  input  logic [DATA_W-1:0]                           tbl_data,
  output logic                                        spi_valid,
  output logic                                        spi_rw,
  output logic [ADDR_W-1:0]                           spi_addr,
  output logic [DATA_W-1:0]                           spi_wdata,
  input  logic                                        spi_ready,
  input  logic                                        spi_rdone,
  input  logic [DATA_W-1:0]                           spi_rdata,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error
);

  localparam int IDX_W = $clog2(NUM_REGS > 1 ? NUM_REGS : 2);
  localparam int CNT_W = $clog2(max2(PWRUP_CYCLES, GAP_CYCLES) + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  state_t state;
  state_t state_next;

  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;
  logic cnt_last;
  logic fetch;
  logic idx_inc;
  logic restart;
`ifdef CFG_READBACK_EN
  logic rb_check;
`endif

  // Reset value of the counter is the power-up hold, so PWRUP needs no load.
  cfg_delay_cnt #(
    .W       (CNT_W),
    .RST_VAL (PWRUP_CYCLES)
  ) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (GAP_LOAD),
    .en       (cnt_en),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_PWRUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    fetch      = 1'b0;
    idx_inc    = 1'b0;
    restart    = 1'b0;
`ifdef CFG_READBACK_EN
    rb_check   = 1'b0;
`endif
    case (state)
      ST_PWRUP: begin
        cnt_en = 1'b1;
        if (cnt_last || cnt_zero) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch      = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (spi_ready) begin
`ifdef CFG_READBACK_EN
          state_next = ST_RB_ISSUE;
`else
          cnt_load   = 1'b1;
          state_next = ST_GAP;
`endif
        end
      end
`ifdef CFG_READBACK_EN
      ST_RB_ISSUE: begin
        if (spi_ready) begin
          state_next = ST_RB_WAIT;
        end
      end
      ST_RB_WAIT: begin
        if (spi_rdone) begin
          rb_check   = 1'b1;
          cnt_load   = 1'b1;
          state_next = ST_GAP;
        end
      end
`endif
      ST_GAP: begin
        cnt_en = 1'b1;
        if (cnt_last || cnt_zero) begin
          if (tbl_idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_inc    = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          restart    = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_idx   <= '0;
      spi_addr  <= '0;
      spi_wdata <= '0;
    end else begin
      if (fetch) begin
        spi_addr  <= tbl_addr;
        spi_wdata <= tbl_data;
      end
      if (restart) begin
        tbl_idx <= '0;
      end else if (idx_inc) begin
        tbl_idx <= tbl_idx + IDX_W'(1);
      end
    end
  end

  // Moore outputs straight off the state register: an async reset drops valid immediately.
  assign busy = (state != ST_DONE);
  assign done = (state == ST_DONE);

`ifdef CFG_READBACK_EN
  assign spi_valid = (state == ST_ISSUE) || (state == ST_RB_ISSUE);
  assign spi_rw    = (state == ST_RB_ISSUE) ? RW_READ : RW_WRITE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (restart) begin
      error <= 1'b0;
    end else if (rb_check && (spi_rdata != spi_wdata)) begin
      error <= 1'b1;
    end
  end
`else
  logic unused_rb;

  assign spi_valid = (state == ST_ISSUE);
  assign spi_rw    = RW_WRITE;
  assign error     = 1'b0;
  assign unused_rb = ^{spi_rdone, spi_rdata};
`endif

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: directed vector runs plus randomized ready/table/readback runs.
// Builds with or without CFG_READBACK_EN.
module tb_codec_cfg_sequencer;

  localparam int NUM_REGS = 4;
  localparam int PWRUP    = 10;
  localparam int GAP      = 3;
`ifdef CFG_READBACK_EN
  localparam int M  = 2;
  localparam bit RB = 1'b1;
`else
  localparam int M  = 1;
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic [6:0] tbl_a;
    logic [7:0] tbl_d;
    logic       exp_rw;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    int         st;
    int         acc;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] tbl_idx;
  logic [6:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       spi_valid;
  logic       spi_rw;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_ready = 1'b0;
  logic       spi_rdone = 1'b0;
  logic [7:0] spi_rdata = 8'h00;
  logic       busy;
  logic       done;
  logic       error;

  logic [6:0] tbl_a [NUM_REGS];
  logic [7:0] tbl_d [NUM_REGS];
  vec_t       vec [NUM_REGS*M];

  txn_t log_q [$];
  int   comp_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   policy   = 0;
  int   hold_cnt = 0;
  int   rd_cnt   = 0;
  int   rd_delay = 0;
  bit   rd_pending = 1'b0;
  bit   new_txn  = 1'b1;
  bit   prev_wait = 1'b0;
  int   cur_start = 0;
  int   bad_idx  = NUM_REGS;
  logic [7:0] bad_val = 8'hFF;
  logic       h_rw;
  logic [6:0] h_addr;
  logic [7:0] h_data;

  assign tbl_addr = tbl_a[tbl_idx];
  assign tbl_data = tbl_d[tbl_idx];

  codec_cfg_sequencer #(
    .NUM_REGS     (NUM_REGS),
    .ADDR_W       (7),
    .DATA_W       (8),
    .PWRUP_CYCLES (PWRUP),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .spi_valid (spi_valid),
    .spi_rw    (spi_rw),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_ready (spi_ready),
    .spi_rdone (spi_rdone),
    .spi_rdata (spi_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI master / codec model: decides ready each cycle, logs accepted transfers, answers reads.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      spi_rdone  = 1'b0;
      rd_pending = 1'b0;
      new_txn    = 1'b1;
      prev_wait  = 1'b0;
      spi_ready  = (policy != 3);
    end else begin
      spi_rdone = 1'b0;
      if (rd_pending) begin
        if (rd_delay == 0) begin
          spi_rdone  = 1'b1;
          spi_rdata  = (rd_cnt == bad_idx) ? bad_val :
                       (rd_cnt < NUM_REGS) ? tbl_d[rd_cnt] : 8'h00;
          rd_cnt++;
          rd_pending = 1'b0;
          comp_q.push_back(cyc);
        end else begin
          rd_delay--;
        end
      end
      if (prev_wait) begin
        check("hold_valid", {31'd0, spi_valid}, 32'd1);
        check("hold_rw",    {31'd0, spi_rw},    {31'd0, h_rw});
        check("hold_addr",  {25'd0, spi_addr},  {25'd0, h_addr});
        check("hold_wdata", {24'd0, spi_wdata}, {24'd0, h_data});
      end
      if (spi_valid && new_txn) begin
        cur_start = cyc;
        new_txn   = 1'b0;
      end
      case (policy)
        0: spi_ready = 1'b1;
        1: spi_ready = 1'($urandom_range(0, 1));
        2: begin
          if (spi_valid && !spi_rw && spi_addr == 7'd1 && hold_cnt < 5) begin
            spi_ready = 1'b0;
            hold_cnt++;
          end else begin
            spi_ready = 1'b1;
          end
        end
        default: spi_ready = 1'b0;
      endcase
      if (spi_valid && spi_ready) begin
        log_q.push_back('{rw: spi_rw, addr: spi_addr, data: spi_wdata, st: cur_start, acc: cyc});
        new_txn   = 1'b1;
        prev_wait = 1'b0;
        if (spi_rw) begin
          rd_pending = 1'b1;
          rd_delay   = $urandom_range(0, 3);
        end else if (!RB) begin
          comp_q.push_back(cyc);
        end
      end else begin
        prev_wait = spi_valid;
        h_rw      = spi_rw;
        h_addr    = spi_addr;
        h_data    = spi_wdata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    comp_q.delete();
    rd_cnt   = 0;
    hold_cnt = 0;
  endtask

  // Expected transfers follow directly from the table: write each entry, then (readback) read it.
  task automatic build_vectors();
    for (int i = 0; i < NUM_REGS; i++) begin
      vec[i*M] = '{tbl_a: tbl_a[i], tbl_d: tbl_d[i], exp_rw: 1'b0,
                   exp_addr: tbl_a[i], exp_data: tbl_d[i]};
      if (RB) begin
        vec[i*M+M-1] = '{tbl_a: tbl_a[i], tbl_d: tbl_d[i], exp_rw: 1'b1,
                         exp_addr: tbl_a[i], exp_data: tbl_d[i]};
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input logic [6:0] addr, input bit any, input string name);
    int n = 0;
    while (!(spi_valid === 1'b1 && !spi_rw && (any || spi_addr == addr)) && n < 200) begin
      tick();
      n++;
    end
    check(name, {31'd0, spi_valid}, 32'd1);
  endtask

  task automatic start_run(output int s);
    tick();
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    check("start_busy",  {31'd0, busy},    32'd1);
    check("start_done",  {31'd0, done},    32'd0);
    check("start_idx",   {30'd0, tbl_idx}, 32'd0);
    check("start_error", {31'd0, error},   32'd0);
  endtask

  task automatic check_run(input int t0, input bit exp_err, input string tag);
    for (int i = 0; i < 8; i++) tick();
    check({tag, "_count"}, log_q.size(), NUM_REGS*M);
    for (int k = 0; k < NUM_REGS*M && k < log_q.size(); k++) begin
      check({tag, "_rw"},   {31'd0, log_q[k].rw},   {31'd0, vec[k].exp_rw});
      check({tag, "_addr"}, {25'd0, log_q[k].addr}, {25'd0, vec[k].exp_addr});
      if (!vec[k].exp_rw) begin
        check({tag, "_data"}, {24'd0, log_q[k].data}, {24'd0, vec[k].exp_data});
      end
    end
    if (log_q.size() > 0) begin
      check({tag, "_first_valid"}, log_q[0].st, t0);
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i*M < log_q.size() && i-1 < comp_q.size()) begin
        check({tag, "_gap"}, log_q[i*M].st, comp_q[i-1] + GAP + 2);
      end
    end
    check({tag, "_done"},  {31'd0, done},    32'd1);
    check({tag, "_busy"},  {31'd0, busy},    32'd0);
    check({tag, "_idx"},   {30'd0, tbl_idx}, NUM_REGS - 1);
    check({tag, "_error"}, {31'd0, error},   {31'd0, exp_err});
  endtask

  initial begin
    int c0;
    int s;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      tbl_a[i] = 7'(i);
      tbl_d[i] = 8'hA0 + 8'(i);
    end
    build_vectors();
    for (int i = 0; i < 3; i++) tick();

    check("rst_idx",   {30'd0, tbl_idx},   32'd0);
    check("rst_valid", {31'd0, spi_valid}, 32'd0);
    check("rst_rw",    {31'd0, spi_rw},    32'd0);
    check("rst_addr",  {25'd0, spi_addr},  32'd0);
    check("rst_wdata", {24'd0, spi_wdata}, 32'd0);
    check("rst_busy",  {31'd0, busy},      32'd1);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_error", {31'd0, error},     32'd0);

    // Power-up run with ready tied high, including during the gaps.
    policy = 0;
    clear_logs();
    @(negedge clk);
    #1;
    rst = 1'b0;
    c0 = cyc;
    wait_done("a_wait_done");
    check_run(c0 + PWRUP + 1, 1'b0, "a");

    // Ready withheld 5 cycles on entry 1; start while busy on entry 2 must be ignored.
    policy = 2;
    clear_logs();
    start_run(s);
    wait_valid(7'd2, 1'b0, "b_wait_entry2");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("b_wait_done");
    check_run(s + 2, 1'b0, "b");
    if (log_q.size() > M) begin
      check("b_hold_cycles", log_q[M].acc - log_q[M].st, 32'd5);
    end

`ifdef CFG_READBACK_EN
    // Bad readback on entry 2: error sticky to the end, then cleared by the next start.
    policy  = 0;
    bad_idx = 2;
    bad_val = 8'hFF;
    clear_logs();
    start_run(s);
    wait_done("c_wait_done");
    check_run(s + 2, 1'b1, "c");
    bad_idx = NUM_REGS;
    clear_logs();
    start_run(s);
    wait_done("c2_wait_done");
    check_run(s + 2, 1'b0, "c2");
`endif

    // Reset while a write is pending: valid drops at once, then a full power-up hold.
    policy = 3;
    clear_logs();
    start_run(s);
    wait_valid(7'd0, 1'b1, "d_wait_valid");
    tick();
    rst = 1'b1;
    #1;
    check("d_rst_valid", {31'd0, spi_valid}, 32'd0);
    check("d_rst_busy",  {31'd0, busy},      32'd1);
    check("d_no_accept", log_q.size(),       32'd0);
    policy = 0;
    tick();
    tick();
    clear_logs();
    @(negedge clk);
    #1;
    rst = 1'b0;
    c0 = cyc;
    wait_done("d_wait_done");
    check_run(c0 + PWRUP + 1, 1'b0, "d");

    // Randomized tables, ready patterns, read latencies and readback faults.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tbl_a[i] = 7'($urandom_range(0, 127));
        tbl_d[i] = 8'($urandom_range(0, 255));
      end
      bad_idx = $urandom_range(0, NUM_REGS);
      bad_val = (bad_idx < NUM_REGS) ? ~tbl_d[bad_idx] : 8'h00;
      policy  = 1;
      build_vectors();
      clear_logs();
      start_run(s);
      wait_done("r_wait_done");
      check_run(s + 2, RB && (bad_idx < NUM_REGS), "r");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
